// File: rtl/glitch_seq_pkg.sv
// Shared types and default widths for the glitch trigger sequencer.
package glitch_seq_pkg;

  localparam int DEF_OFFSET_W = 32;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    FIRE,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for an asynchronous trigger, plus a rising-edge detector.
// The flops free-run so that a level already present never looks like a fresh edge.
module trig_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // NOTE: non-blocking assignments let each flop see the previous value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_prev;

endmodule

// File: rtl/glitch_trigger_sequencer.sv
// Armed trigger sequencer: waits for an external edge, counts an offset, then issues
// a train of single-cycle glitch_go pulses with programmable count and spacing.
module glitch_trigger_sequencer
  import glitch_seq_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exttrig,
  input  logic                arm,
  input  logic                disarm,
  input  logic                continuous,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [OFFSET_W-1:0] spacing,
  input  logic [CNT_W-1:0]    num_pulses,
  output logic                glitch_go,
  output logic                armed,
  output logic                busy,
  output logic                done,
  output logic                missed
);

  state_t              r_state, w_next_state;
  logic [OFFSET_W-1:0] r_cnt, w_cnt_next;
  logic [OFFSET_W-1:0] r_spacing, w_spacing_next;
  logic [CNT_W-1:0]    r_left, w_left_next;
  logic                r_missed, w_missed_next;
  logic                r_glitch_go, r_armed, r_busy, r_done;
  logic                w_edge;

  trig_edge_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (exttrig),
    .o_edge  (w_edge)
  );

  // Counters are loaded with value-1 so a zero offset/spacing skips the wait state entirely.
  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_spacing_next = r_spacing;
    w_left_next    = r_left;
    w_missed_next  = r_missed;

    unique case (r_state)
      IDLE: begin
        if (arm && !disarm) begin
          w_next_state  = ARMED;
          w_missed_next = 1'b0;
        end
      end
      ARMED: begin
        if (w_edge) begin
          w_spacing_next = spacing;
          w_left_next    = (num_pulses == '0) ? '0 : num_pulses - CNT_W'(1);
          if (offset == '0) begin
            w_next_state = FIRE;
          end else begin
            w_next_state = DELAY;
            w_cnt_next   = offset - OFFSET_W'(1);
          end
        end
      end
      DELAY, GAP: begin
        if (r_cnt == '0) w_next_state = FIRE;
        else             w_cnt_next   = r_cnt - OFFSET_W'(1);
      end
      FIRE: begin
        if (r_left == '0) begin
          w_next_state = DONE;
        end else begin
          w_left_next = r_left - CNT_W'(1);
          if (r_spacing == '0) begin
            w_next_state = FIRE;
          end else begin
            w_next_state = GAP;
            w_cnt_next   = r_spacing - OFFSET_W'(1);
          end
        end
      end
      DONE:    w_next_state = continuous ? ARMED : IDLE;
      default: w_next_state = IDLE;
    endcase

    if (w_edge && ((r_state inside {DELAY, FIRE, GAP}) || (r_state == DONE && continuous)))
      w_missed_next = 1'b1;

    if (disarm && r_state != IDLE)
      w_next_state = IDLE;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_spacing   <= '0;
      r_left      <= '0;
      r_missed    <= 1'b0;
      r_glitch_go <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_spacing   <= w_spacing_next;
      r_left      <= w_left_next;
      r_missed    <= w_missed_next;
      r_glitch_go <= (w_next_state == FIRE);
      r_armed     <= (w_next_state == ARMED);
      r_busy      <= (w_next_state inside {DELAY, FIRE, GAP});
      r_done      <= (w_next_state == DONE);
    end
  end

  assign glitch_go = r_glitch_go;
  assign armed     = r_armed;
  assign busy      = r_busy;
  assign done      = r_done;
  assign missed    = r_missed;

endmodule

// File: tb/tb_glitch_trigger_sequencer.sv
// Scoreboard bench: stimulus queues expected glitch_go/done events with their cycle
// numbers; a negedge monitor pops and compares every event the DUT presents.
module tb_glitch_trigger_sequencer;

  localparam int OFFSET_W = 32;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic is_done;
    int   cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                exttrig = 1'b0;
  logic                arm = 1'b0;
  logic                disarm = 1'b0;
  logic                continuous = 1'b0;
  logic [OFFSET_W-1:0] offset = '0;
  logic [OFFSET_W-1:0] spacing = '0;
  logic [CNT_W-1:0]    num_pulses = '0;
  logic                glitch_go, armed, busy, done, missed;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  glitch_trigger_sequencer #(.OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .exttrig    (exttrig),
    .arm        (arm),
    .disarm     (disarm),
    .continuous (continuous),
    .offset     (offset),
    .spacing    (spacing),
    .num_pulses (num_pulses),
    .glitch_go  (glitch_go),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .missed     (missed)
  );

  always #25 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input logic is_done, input int at_cyc);
    exp_t e;
    e.is_done = is_done;
    e.cyc     = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic score(input logic is_done);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s at cycle %0d: got event expected none",
               is_done ? "done" : "glitch_go", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done !== is_done || e.cyc != cyc) begin
        n_errors++;
        $display("FAIL event_order: got %s at cycle %0d expected %s at cycle %0d",
                 is_done ? "done" : "glitch_go", cyc, e.is_done ? "done" : "glitch_go", e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (glitch_go === 1'b1) score(1'b0);
    if (done === 1'b1)      score(1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
  endtask

  task automatic set_cfg(input int o, input int s, input int np, input logic c);
    offset     = OFFSET_W'(o);
    spacing    = OFFSET_W'(s);
    num_pulses = CNT_W'(np);
    continuous = c;
  endtask

  initial begin
    int n;
    int m;

    // Reset state
    step(3);
    reset = 1'b0;
    check("rst_glitch_go", glitch_go, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_missed", missed, 0);

    // Basic timing: offset 0, one pulse, 500 ns trigger
    set_cfg(0, 0, 1, 1'b0);
    pulse_arm();
    check("basic_armed", armed, 1);
    n = cyc;
    expect_ev(1'b0, n + 3);
    expect_ev(1'b1, n + 4);
    exttrig = 1'b1;
    step(10);
    exttrig = 1'b0;
    check("basic_armed_after", armed, 0);
    check("basic_busy_after", busy, 0);
    step(3);

    // Offset 5, three pulses, spacing 2; inputs changed mid-run must not matter
    set_cfg(5, 2, 3, 1'b0);
    pulse_arm();
    n = cyc;
    expect_ev(1'b0, n + 8);
    expect_ev(1'b0, n + 11);
    expect_ev(1'b0, n + 14);
    expect_ev(1'b1, n + 15);
    exttrig = 1'b1;
    step(2);
    exttrig = 1'b0;
    step(1);
    check("train_busy_E+1", busy, 1);
    set_cfg(0, 0, 1, 1'b0);
    step(11);
    check("train_busy_E+12", busy, 1);
    step(1);
    check("train_busy_E+13", busy, 0);
    step(3);

    // Short 5 ns trigger straddling the sampling edge
    set_cfg(0, 0, 1, 1'b0);
    pulse_arm();
    n = cyc;
    expect_ev(1'b0, n + 3);
    expect_ev(1'b1, n + 4);
    #22 exttrig = 1'b1;
    #5  exttrig = 1'b0;
    step(6);
    check("short_caught_armed", armed, 0);

    // Short trigger missing every sampling edge
    pulse_arm();
    #5 exttrig = 1'b1;
    #5 exttrig = 1'b0;
    step(6);
    check("short_missed_armed", armed, 1);
    check("short_missed_busy", busy, 0);
    pulse_disarm();
    check("disarm_armed", armed, 0);

    // A level already high when arming is not an edge
    exttrig = 1'b1;
    step(4);
    pulse_arm();
    step(4);
    exttrig = 1'b0;
    step(3);
    check("stale_level_armed", armed, 1);
    pulse_disarm();
    step(1);

    // num_pulses 0 behaves as 1
    set_cfg(1, 3, 0, 1'b0);
    pulse_arm();
    n = cyc;
    expect_ev(1'b0, n + 4);
    expect_ev(1'b1, n + 5);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(8);

    // Continuous mode with a missed edge during GAP
    set_cfg(2, 4, 2, 1'b1);
    pulse_arm();
    check("cont_missed_clear", missed, 0);
    n = cyc;
    expect_ev(1'b0, n + 5);
    expect_ev(1'b0, n + 10);
    expect_ev(1'b1, n + 11);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(4);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(3);
    check("cont_missed_set", missed, 1);
    step(3);
    check("cont_rearmed", armed, 1);
    check("cont_missed_sticky", missed, 1);
    step(1);
    m = cyc;
    expect_ev(1'b0, m + 5);
    expect_ev(1'b0, m + 10);
    expect_ev(1'b1, m + 11);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(11);
    check("cont_rearmed2", armed, 1);
    check("cont_missed_still", missed, 1);
    continuous = 1'b0;
    pulse_disarm();
    check("missed_after_disarm", missed, 1);
    pulse_arm();
    check("missed_cleared_by_arm", missed, 0);

    // Abort during a long DELAY
    set_cfg(100, 0, 1, 1'b0);
    n = cyc;
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(9);
    check("abort_busy_before", busy, 1);
    pulse_disarm();
    check("abort_busy", busy, 0);
    check("abort_armed", armed, 0);
    step(120);

    // Simultaneous arm and disarm in IDLE
    arm = 1'b1;
    disarm = 1'b1;
    step(1);
    arm = 1'b0;
    disarm = 1'b0;
    check("arm_disarm_armed", armed, 0);
    step(3);
    check("arm_disarm_armed_later", armed, 0);

    // Reset mid-sequence, after an edge in DELAY has set missed
    set_cfg(3, 5, 4, 1'b0);
    pulse_arm();
    n = cyc;
    expect_ev(1'b0, n + 6);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(1);
    exttrig = 1'b1;
    step(1);
    exttrig = 1'b0;
    step(4);
    check("mid_missed", missed, 1);
    step(1);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_glitch_go", glitch_go, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_armed", armed, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_missed", missed, 0);
    step(25);
    check("mid_rst_idle_busy", busy, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/glitch_trigger_sequencer.md
Name: glitch_trigger_sequencer

Overview:
Arms on request and waits for a rising edge on the external trigger. It then counts a programmable offset and issues a train of single-cycle glitch_go pulses with programmable count and spacing. This is the scheduling layer between the scope's external-trigger input and the clock-glitch generator. It replaces a bare resync-plus-offset path with an armed, countable, re-armable sequence.

Parameters:
OFFSET_W, 32, width of offset and spacing counters
CNT_W, 8, width of pulse-count field

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
exttrig  in  1  raw external trigger, asynchronous to clk
arm  in  1  single-cycle arm request
disarm  in  1  single-cycle abort request
continuous  in  1  1 = re-arm automatically after each sequence
offset  in  OFFSET_W  cycles from edge detect to first pulse
spacing  in  OFFSET_W  idle cycles between consecutive pulses
num_pulses  in  CNT_W  pulses per sequence; 0 is treated as 1
glitch_go  out  1  one-cycle glitch request
armed  out  1  high while waiting for a trigger edge
busy  out  1  high from edge detect until the last pulse is issued
done  out  1  one-cycle pulse in the cycle after the last glitch_go
missed  out  1  sticky; a trigger edge arrived while busy

Behaviour:
- Reset values: glitch_go=0, armed=0, busy=0, done=0, missed=0. Synchronizer flops = 0, state = IDLE, counters = 0. Reset takes priority over every other input and aborts any operation in progress.
- Synchronizer: 2 flops, then a previous-value register. edge = sync2 & ~prev.
  - exttrig sampled high at clk edge k makes edge high in cycle k+2, called cycle E.
  - Synchronizer flops free-run in every state, so a stale level never produces an edge on arming.
- IDLE: arm -> ARMED, clear missed. armed=1 from the next cycle.
- ARMED: edge -> DELAY.
  - In cycle E, latch offset, spacing and num_pulses (0 -> 1) into shadow registers.
  - In cycle E, load the delay counter with the latched offset. busy=1 from E+1.
  - Input changes after E do not affect the running sequence.
- DELAY: counter reaches 0 -> FIRE.
  - offset=0: glitch_go in cycle E+1.
  - offset=N: glitch_go in cycle E+1+N.
- FIRE: glitch_go=1 for exactly one cycle; decrement the remaining-pulse count.
  - Count remaining -> GAP, loaded with spacing. spacing=S puts the next pulse S+1 cycles after the previous one; S=0 gives back-to-back pulses.
  - Last pulse -> DONE.
- GAP: counter reaches 0 -> FIRE.
- DONE: done=1 for one cycle, busy=0.
  - continuous=1 -> ARMED.
  - continuous=0 -> IDLE.
- disarm in any non-IDLE state -> IDLE next cycle. No further glitch_go and no done pulse. Outputs clear next cycle.
- arm while busy or armed: ignored.
- arm and disarm in the same cycle: disarm wins.
- An edge in DELAY, FIRE or GAP sets missed (sticky until the next accepted arm) and does not restart the sequence.
- An edge in the DONE cycle with continuous=1 is also counted as missed. Re-arm takes effect the cycle after DONE.
- Counters are unsigned, offset up to 2^OFFSET_W-1, and must not wrap or underflow. Terminal detection is on ==0.
- All outputs are registered.

Decomposition:
- Shared package glitch_seq_pkg holds:
  - the state enum: IDLE, ARMED, DELAY, FIRE, GAP, DONE
  - default widths OFFSET_W=32 and CNT_W=8
- One sub-module: trig_edge_sync, containing the 2-flop synchronizer, previous-value register and rising-edge output. It is reused by other trigger paths.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-sequence (busy=1): assert reset 1 cycle -> all outputs 0 next cycle, no further glitch_go, state IDLE.
- Basic timing: offset=0, num_pulses=1, exttrig high 500 ns (clk period 50 ns) -> exactly 1 glitch_go at E+1, then done at E+2, then armed=0.
- Offset and train: offset=5, num_pulses=3, spacing=2 -> glitch_go at E+6, E+9, E+12; done at E+13; busy high E+1..E+12.
- Short trigger and edge cases:
  - 5 ns exttrig pulse caught by the sampling edge -> sequence runs.
  - Pulse not caught -> no edge; stays armed.
  - num_pulses=0 -> one pulse.
- Missed and continuous: continuous=1, second exttrig edge during GAP -> missed=1, train unaffected. Re-arms after done; third edge starts a new train. missed clears only on an explicit arm.
- Abort: disarm during DELAY with offset=100 -> IDLE next cycle, no glitch_go, no done. Simultaneous arm+disarm in IDLE -> stays IDLE.
